// File: rtl/conv_window_collector.sv
// Keeps only the full-window 5x5 convolution results from a raster stream and queues them in a
// small valid/ready FIFO, tagging the last result of each frame. Optional ReLU clamp: CONV_RELU_EN.
module conv_window_collector #(
   parameter int IMAGE_WIDTH  = 28,
   parameter int KERNEL_WIDTH = 5,
   parameter int DATA_WIDTH   = 39,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         in_valid,
   input  logic signed [DATA_WIDTH-1:0] data_in,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic signed [DATA_WIDTH-1:0] data_out,
   output logic                         out_last,
   output logic                         frame_done,
   output logic                         overflow
);

   localparam int CNT_W = $clog2(IMAGE_WIDTH);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(IMAGE_WIDTH - 1);
   localparam logic [CNT_W-1:0] KEEP_MIN = CNT_W'(KERNEL_WIDTH - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

   logic [CNT_W-1:0] col_q, col_d, row_q, row_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   count_q, count_d;
   logic             frame_done_q, overflow_q;
   logic [DATA_WIDTH:0] mem_q [FIFO_DEPTH];

   logic                  keep, at_end, full, pop, push, drop;
   logic [DATA_WIDTH-1:0] wdata;
   logic [DATA_WIDTH:0]   head;

   assign keep   = in_valid && (row_q >= KEEP_MIN) && (col_q >= KEEP_MIN);
   assign at_end = (row_q == LAST_POS) && (col_q == LAST_POS);
   assign full   = (count_q == FULL_CNT);
   assign pop    = out_valid && out_ready;
   // A full FIFO still takes a new result when the head leaves in the same cycle.
   assign push   = keep && (!full || pop);
   assign drop   = keep && !push;

`ifdef CONV_RELU_EN
   assign wdata = data_in[DATA_WIDTH-1] ? '0 : data_in;
`else
   assign wdata = data_in;
`endif

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (in_valid) begin
         if (col_q == LAST_POS) begin
            col_d = '0;
            row_d = (row_q == LAST_POS) ? '0 : row_q + 1'b1;
         end else begin
            col_d = col_q + 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q        <= '0;
         row_q        <= '0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         col_q        <= col_d;
         row_q        <= row_d;
         count_q      <= count_d;
         frame_done_q <= in_valid && at_end;
         if (drop) overflow_q <= 1'b1;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // NOTE: storage is not reset; the occupancy count alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {in_valid && at_end, wdata};
   end

   assign head       = mem_q[rd_ptr_q];
   assign out_valid  = (count_q != '0);
   assign data_out   = out_valid ? $signed(head[DATA_WIDTH-1:0]) : '0;
   assign out_last   = out_valid && head[DATA_WIDTH];
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_window_collector.sv
// Self-checking bench for conv_window_collector: queue-based window/FIFO reference model,
// directed frames and randomized traffic. Honours CONV_RELU_EN for expected data.
module tb_conv_window_collector;

   localparam int W    = 28;
   localparam int K    = 5;
   localparam int DW   = 39;
   localparam int D    = 8;
   localparam int NPIX = W * W;
`ifdef CONV_RELU_EN
   localparam int NEG5_EXP = 0;
`else
   localparam int NEG5_EXP = -5;
`endif

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 in_valid;
   logic signed [DW-1:0] data_in;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [DW-1:0] data_out;
   logic                 out_last;
   logic                 frame_done;
   logic                 overflow;

   conv_window_collector #(
      .IMAGE_WIDTH (W),
      .KERNEL_WIDTH(K),
      .DATA_WIDTH  (DW),
      .FIFO_DEPTH  (D)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .data_in   (data_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .out_last  (out_last),
      .frame_done(frame_done),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                   last;
      logic signed [DW-1:0] data;
   } entry_t;

   entry_t mq[$];
   int     m_idx;
   bit     m_ovf;
   bit     m_fd;

   int errors = 0;
   int checks = 0;

   int                   n_pops, n_lasts, n_fd;
   bit                   seen_first;
   logic signed [DW-1:0] first_pop, last_pop;
   bit                   last_pop_flag;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_keep(input int idx);
      return ((idx / W) >= K - 1) && ((idx % W) >= K - 1);
   endfunction

   function automatic logic signed [DW-1:0] relu(input logic signed [DW-1:0] v);
`ifdef CONV_RELU_EN
      return (v < 0) ? '0 : v;
`else
      return v;
`endif
   endfunction

   function automatic logic signed [DW-1:0] rand_data();
      logic [63:0] t;
      t = {$urandom(), $urandom()};
      return $signed(t[DW-1:0]);
   endfunction

   task automatic clear_stats();
      n_pops = 0; n_lasts = 0; n_fd = 0; seen_first = 0;
      first_pop = '0; last_pop = '0; last_pop_flag = 0;
   endtask

   task automatic compare_model();
      check("out_valid", 64'(out_valid), 64'(mq.size() != 0));
      if (mq.size() != 0) begin
         check("data_out", 64'(data_out), 64'(mq[0].data));
         check("out_last", 64'(out_last), 64'(mq[0].last));
      end
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("frame_done", 64'(frame_done), 64'(m_fd));
      if (frame_done) n_fd++;
   endtask

   // One clock: drive inputs, observe any handshake, advance the model across the edge, compare.
   task automatic cycle(input bit v, input logic signed [DW-1:0] d, input bit rdy);
      bit pop, push, keep;
      in_valid  = v;
      data_in   = d;
      out_ready = rdy;
      #1;
      if (out_valid && out_ready) begin
         n_pops++;
         if (!seen_first) begin
            first_pop  = data_out;
            seen_first = 1;
         end
         last_pop      = data_out;
         last_pop_flag = out_last;
         if (out_last) n_lasts++;
      end
      pop  = (mq.size() != 0) && rdy;
      keep = v && is_keep(m_idx);
      push = keep && ((mq.size() < D) || pop);
      @(posedge clk);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{last: (m_idx == NPIX - 1), data: relu(d)});
      if (keep && !push) m_ovf = 1;
      m_fd = v && (m_idx == NPIX - 1);
      if (v) m_idx = (m_idx + 1) % NPIX;
      #1;
      compare_model();
   endtask

   task automatic do_reset();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      #2;
      reset_n = 1'b0;
      mq.delete();
      m_idx = 0; m_ovf = 0; m_fd = 0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_data_out", 64'(data_out), 64'(0));
      check("rst_out_last", 64'(out_last), 64'(0));
      check("rst_frame_done", 64'(frame_done), 64'(0));
      check("rst_overflow", 64'(overflow), 64'(0));
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      data_in   = '0;
      #1;

      // Full frame, raster index data, sink always ready.
      do_reset();
      clear_stats();
      for (int i = 0; i < NPIX; i++) cycle(1'b1, DW'(i), 1'b1);
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      check("t1_count", 64'(n_pops), 64'(576));
      check("t1_first", 64'(first_pop), 64'(116));
      check("t1_last_val", 64'(last_pop), 64'(783));
      check("t1_last_flag", 64'(last_pop_flag), 64'(1));
      check("t1_last_cnt", 64'(n_lasts), 64'(1));
      check("t1_frame_done", 64'(n_fd), 64'(1));
      check("t1_overflow", 64'(overflow), 64'(0));

      // Same frame with the sink stalled: FIFO fills with 116..123, overflow on 124.
      do_reset();
      clear_stats();
      for (int i = 0; i < NPIX; i++) begin
         cycle(1'b1, DW'(i), 1'b0);
         if (i == 123) check("t2_no_ovf_123", 64'(overflow), 64'(0));
         if (i == 124) check("t2_ovf_124", 64'(overflow), 64'(1));
      end
      check("t2_valid", 64'(out_valid), 64'(1));
      check("t2_head", 64'(data_out), 64'(116));
      check("t2_pops", 64'(n_pops), 64'(0));
      check("t2_frame_done", 64'(n_fd), 64'(1));

      // Full FIFO, pop and keep in the same cycle; then signed data through the clamp.
      do_reset();
      clear_stats();
      for (int i = 0; i < 124; i++) cycle(1'b1, DW'(i), 1'b0);
      cycle(1'b1, DW'(124), 1'b1);
      check("t3_no_ovf", 64'(overflow), 64'(0));
      check("t3_head", 64'(data_out), 64'(117));
      for (int i = 0; i < D; i++) cycle(1'b0, '0, 1'b1);
      check("t3_drained", 64'(out_valid), 64'(0));
      check("t3_order_last", 64'(last_pop), 64'(124));
      cycle(1'b1, -DW'(5), 1'b0);
      check("t3_neg5", 64'(data_out), 64'(NEG5_EXP));
      cycle(1'b1, DW'(7), 1'b1);
      check("t3_pos7", 64'(data_out), 64'(7));
      check("t3_no_ovf_end", 64'(overflow), 64'(0));

      // Reset mid-frame with entries queued, then a clean frame.
      do_reset();
      for (int i = 0; i < 300; i++) cycle(1'b1, DW'(i), i < 298);
      check("t4_queued", 64'(out_valid), 64'(1));
      do_reset();
      clear_stats();
      for (int i = 0; i < NPIX; i++) cycle(1'b1, DW'(i), 1'b1);
      check("t4_first", 64'(first_pop), 64'(116));

      // Two back-to-back frames, in_valid one cycle in three, random data.
      do_reset();
      clear_stats();
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < NPIX; i++) begin
            cycle(1'b1, rand_data(), 1'b1);
            cycle(1'b0, rand_data(), 1'b1);
            cycle(1'b0, rand_data(), 1'b1);
         end
      end
      for (int i = 0; i < 4; i++) cycle(1'b0, '0, 1'b1);
      check("t5_count", 64'(n_pops), 64'(1152));
      check("t5_lasts", 64'(n_lasts), 64'(2));
      check("t5_frame_done", 64'(n_fd), 64'(2));
      check("t5_overflow", 64'(overflow), 64'(0));

      // Random valid/ready/data traffic against the model, overflow allowed.
      do_reset();
      for (int i = 0; i < 3000; i++)
         cycle(($urandom_range(0, 99) < 60), rand_data(), ($urandom_range(0, 99) < 45));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
